vga_pattern_gen: RTL
====================

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, vertical widths in lines.
REQ-004 SHALL have parameter CLK_DIV, default 4, clk_100mhz cycles per pixel (>=1).
REQ-005 SHALL have parameter COLOR_W, default 4, bits per colour channel.
REQ-006 SHALL have parameter SYNC_POL, default 0, active level of hsync/vsync.
REQ-007 SHALL have parameter CHK_SHIFT, default 5, log2 of checker square size.
REQ-008 clk_100mhz  input  1  system clock; single clock domain.
REQ-009 rst_n  input  1  asynchronous, active-low reset.
REQ-010 mode  input  2  pattern select: 0 bars, 1 checker, 2 gradient, 3 solid.
REQ-011 solid_rgb  input  3*COLOR_W  {r,g,b} colour for mode 3.
REQ-012 hsync, vsync  output  1  sync pulses at SYNC_POL.
REQ-013 vga_r, vga_g, vga_b  output  COLOR_W  pixel colour.
REQ-014 de  output  1  high during active video.
REQ-015 frame_start  output  1  one-clk pulse at first pixel of a frame.
REQ-016 pix_x, pix_y  output  clog2 width  current active coordinate.
REQ-017 frame_cnt  output  16  frames completed.

Function
REQ-018 Divider counts 0..CLK_DIV-1; pix_en high when count = CLK_DIV-1; CLK_DIV=1 -> pix_en permanently high.
REQ-019 h_cnt increments on pix_en, wraps at H_TOTAL-1 (H_TOTAL = sum of H params) to 0; v_cnt increments on that wrap, wraps at V_TOTAL-1.
REQ-020 Active when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; hsync asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync same rule on v_cnt.
REQ-021 All outputs registered; decoded from counter values with exactly one clk latency; hsync/vsync/de/rgb/pix_x/pix_y mutually aligned.
REQ-022 rgb forced to 0 whenever de=0.
REQ-023 Mode 0: bar = (pix_x*8)/H_ACTIVE; each channel all-ones if its bit set ({r,g,b} = bar[2:0]), else 0.
REQ-024 Mode 1: all channels all-ones when pix_x[CHK_SHIFT]^pix_y[CHK_SHIFT], else 0.
REQ-025 Mode 2: r = (pix_x + scroll) mod 2^COLOR_W, g = pix_y mod 2^COLOR_W, b = r^g.
REQ-026 Mode 3: channels from solid_rgb.
REQ-027 mode and solid_rgb sampled into shadow registers only when h_cnt=0, v_cnt=0 and pix_en; mid-frame changes take effect next frame.
REQ-028 frame_start pulses for one clk (not one pixel) aligned with first active pixel output.
REQ-029 frame_cnt increments when frame_start pulses; wraps 0xFFFF -> 0.

Reset
REQ-030 rst_n low: divider, h_cnt, v_cnt, shadow mode (0), frame_cnt cleared immediately.
REQ-031 During reset: hsync=vsync=~SYNC_POL, de=0, rgb=0, frame_start=0, pix_x=pix_y=0.
REQ-032 Reset deassertion mid-frame restarts timing at h_cnt=0, v_cnt=0; first frame_start one clk after first pix_en.

Configuration
REQ-033 Macro VGA_SCROLL_EN: defined -> scroll = frame_cnt[COLOR_W-1:0] (gradient moves one step per frame); undefined -> scroll = 0; frame_cnt port present either way.

Structure
REQ-034 Package vga_pkg holds mode enum (BARS, CHECKER, GRADIENT, SOLID) and default 640x480 timing constants.
REQ-035 One sub-module vga_timing (divider, counters, sync/de decode); pattern logic stays in top.

Verification (params: H 8/2/2/2, V 4/1/1/1, CLK_DIV=2, COLOR_W=4, SYNC_POL=0)
REQ-036 Free run after reset -> hsync period 28 clk, low 4 clk; vsync period 196 clk, low 28 clk.
REQ-037 Mode 0 -> per line, de-high pixels give {r,g,b} = 0,1,...,7 bars, each 2 clk wide; rgb=0 when de=0.
REQ-038 Mode 3, solid_rgb=0xABC changed to 0x123 mid-frame -> 0xABC until next frame_start, then 0x123.
REQ-039 rst_n low for 3 clk at h_cnt=5,v_cnt=2 -> outputs at reset values at once; frame_start 2 clk after release.
REQ-040 Mode 2 with VGA_SCROLL_EN, 3 frames -> pixel (0,0) r = 0,1,2; without macro r = 0 each frame.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared mode encoding and default 640x480 timing for the VGA pattern generator.
package vga_pkg;

    typedef enum logic [1:0] {
        BARS     = 2'd0,
        CHECKER  = 2'd1,
        GRADIENT = 2'd2,
        SOLID    = 2'd3
    } vga_mode_e;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Video output bundle of the pattern generator: syncs, colour, coordinates, frame status.
interface vga_pattern_gen_if #(
    parameter int COLOR_W = 4,
    parameter int X_W     = 10,
    parameter int Y_W     = 9
);
    logic               hsync;
    logic               vsync;
    logic               de;
    logic               frame_start;
    logic [COLOR_W-1:0] vga_r;
    logic [COLOR_W-1:0] vga_g;
    logic [COLOR_W-1:0] vga_b;
    logic [X_W-1:0]     pix_x;
    logic [Y_W-1:0]     pix_y;
    logic [15:0]        frame_cnt;

    modport master (
        output hsync, vsync, de, frame_start,
        output vga_r, vga_g, vga_b,
        output pix_x, pix_y, frame_cnt
    );

    modport slave (
        input hsync, vsync, de, frame_start,
        input vga_r, vga_g, vga_b,
        input pix_x, pix_y, frame_cnt
    );
endinterface

// File: rtl/vga_timing.sv
// Pixel divider, h/v counters and registered sync/de/coordinate decode.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int CLK_DIV  = 4,
    parameter int SYNC_POL = 0,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL),
    localparam int X_W     = $clog2(H_ACTIVE),
    localparam int Y_W     = $clog2(V_ACTIVE)
) (
    input  logic           clk_100mhz,
    input  logic           rst_n,
    output logic           pix_en,
    output logic [HW-1:0]  h_cnt,
    output logic [VW-1:0]  v_cnt,
    output logic           active,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic           frame_start,
    output logic [X_W-1:0] pix_x,
    output logic [Y_W-1:0] pix_y
);

    localparam logic        SYNC_ON   = 1'(SYNC_POL);
    localparam int unsigned HS_START  = H_ACTIVE + H_FP;
    localparam int unsigned HS_END    = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_START  = V_ACTIVE + V_FP;
    localparam int unsigned VS_END    = V_ACTIVE + V_FP + V_SYNC;

    generate
        if (CLK_DIV == 1) begin : g_nodiv
            assign pix_en = 1'b1;
        end else begin : g_div
            localparam int DW = $clog2(CLK_DIV);
            logic [DW-1:0] div_q, div_d;

            assign pix_en = (div_q == DW'(CLK_DIV - 1));
            always_comb div_d = pix_en ? '0 : div_q + 1'b1;

            always_ff @(posedge clk_100mhz or negedge rst_n) begin
                if (!rst_n) div_q <= '0;
                else        div_q <= div_d;
            end
        end
    endgenerate

    logic [HW-1:0]  h_cnt_q, h_cnt_d;
    logic [VW-1:0]  v_cnt_q, v_cnt_d;
    logic           h_last, v_last;
    logic           hsync_q, hsync_d, vsync_q, vsync_d;
    logic           de_q, fs_q, fs_d;
    logic [X_W-1:0] pix_x_q, pix_x_d;
    logic [Y_W-1:0] pix_y_q, pix_y_d;

    assign h_last = (h_cnt_q == HW'(H_TOTAL - 1));
    assign v_last = (v_cnt_q == VW'(V_TOTAL - 1));

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_en) begin
            h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
            if (h_last) v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
        end
    end

    // Decode runs every clk, so the outputs trail the counters by exactly one clk.
    always_comb begin
        active  = (32'(h_cnt_q) < 32'(H_ACTIVE)) && (32'(v_cnt_q) < 32'(V_ACTIVE));
        hsync_d = ((32'(h_cnt_q) >= HS_START) && (32'(h_cnt_q) < HS_END)) ? SYNC_ON : ~SYNC_ON;
        vsync_d = ((32'(v_cnt_q) >= VS_START) && (32'(v_cnt_q) < VS_END)) ? SYNC_ON : ~SYNC_ON;
        fs_d    = pix_en && (h_cnt_q == '0) && (v_cnt_q == '0);
        pix_x_d = active ? X_W'(h_cnt_q) : '0;
        pix_y_d = active ? Y_W'(v_cnt_q) : '0;
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            hsync_q <= ~SYNC_ON;
            vsync_q <= ~SYNC_ON;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
            pix_x_q <= '0;
            pix_y_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= active;
            fs_q    <= fs_d;
            pix_x_q <= pix_x_d;
            pix_y_q <= pix_y_d;
        end
    end

    assign h_cnt       = h_cnt_q;
    assign v_cnt       = v_cnt_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign frame_start = fs_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: bars, checker, gradient or solid colour over vga_timing.
// Optional macro VGA_SCROLL_EN scrolls the gradient by one step per frame.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int CLK_DIV   = 4,
    parameter int COLOR_W   = 4,
    parameter int SYNC_POL  = 0,
    parameter int CHK_SHIFT = 5,
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW       = $clog2(H_TOTAL),
    localparam int VW       = $clog2(V_TOTAL),
    localparam int X_W      = $clog2(H_ACTIVE),
    localparam int Y_W      = $clog2(V_ACTIVE)
) (
    input  logic                 clk_100mhz,
    input  logic                 rst_n,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] solid_rgb,
    vga_pattern_gen_if.master    vid
);

    logic           pix_en, active, hsync, vsync, de, frame_start;
    logic [HW-1:0]  h_cnt;
    logic [VW-1:0]  v_cnt;
    logic [X_W-1:0] pix_x;
    logic [Y_W-1:0] pix_y;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .CLK_DIV  (CLK_DIV),  .SYNC_POL (SYNC_POL)
    ) u_timing (
        .clk_100mhz  (clk_100mhz),
        .rst_n       (rst_n),
        .pix_en      (pix_en),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .active      (active),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .frame_start (frame_start),
        .pix_x       (pix_x),
        .pix_y       (pix_y)
    );

    vga_mode_e            mode_q, mode_d;
    logic [3*COLOR_W-1:0] solid_q, solid_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic [COLOR_W-1:0]   r_q, r_d, g_q, g_d, b_q, b_d;
    logic [COLOR_W-1:0]   scroll, grad_r, grad_g;
    logic [2:0]           bar;
    logic                 chk;
    logic                 frame_load;

`ifdef VGA_SCROLL_EN
    assign scroll = frame_cnt_q[COLOR_W-1:0];
`else
    assign scroll = '0;
`endif

    assign frame_load = pix_en && (h_cnt == '0) && (v_cnt == '0);

    // The pattern decodes from the next shadow value so the new frame's settings
    // appear on the same clk as frame_start.
    always_comb begin
        mode_d  = mode_q;
        solid_d = solid_q;
        if (frame_load) begin
            mode_d  = vga_mode_e'(mode);
            solid_d = solid_rgb;
        end
    end

    always_comb frame_cnt_d = frame_start ? frame_cnt_q + 16'd1 : frame_cnt_q;

    always_comb begin
        bar    = 3'((32'(h_cnt) * 32'd8) / 32'(H_ACTIVE));
        chk    = 1'((32'(h_cnt) ^ 32'(v_cnt)) >> CHK_SHIFT);
        grad_r = COLOR_W'(32'(h_cnt) + 32'(scroll));
        grad_g = COLOR_W'(v_cnt);
        r_d    = '0;
        g_d    = '0;
        b_d    = '0;
        if (active) begin
            unique case (mode_d)
                BARS: begin
                    r_d = {COLOR_W{bar[2]}};
                    g_d = {COLOR_W{bar[1]}};
                    b_d = {COLOR_W{bar[0]}};
                end
                CHECKER: begin
                    r_d = {COLOR_W{chk}};
                    g_d = {COLOR_W{chk}};
                    b_d = {COLOR_W{chk}};
                end
                GRADIENT: begin
                    r_d = grad_r;
                    g_d = grad_g;
                    b_d = grad_r ^ grad_g;
                end
                SOLID: begin
                    r_d = solid_d[3*COLOR_W-1:2*COLOR_W];
                    g_d = solid_d[2*COLOR_W-1:COLOR_W];
                    b_d = solid_d[COLOR_W-1:0];
                end
            endcase
        end
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= BARS;
            solid_q     <= '0;
            frame_cnt_q <= '0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
        end else begin
            mode_q      <= mode_d;
            solid_q     <= solid_d;
            frame_cnt_q <= frame_cnt_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
        end
    end

    assign vid.hsync       = hsync;
    assign vid.vsync       = vsync;
    assign vid.de          = de;
    assign vid.frame_start = frame_start;
    assign vid.pix_x       = pix_x;
    assign vid.pix_y       = pix_y;
    assign vid.vga_r       = r_q;
    assign vid.vga_g       = g_q;
    assign vid.vga_b       = b_q;
    assign vid.frame_cnt   = frame_cnt_q;

endmodule
